// File: rtl/ring_pkg.sv
// Shared types and defaults for ring-phase consumers.
// Optional error counter: RING_PHASE_DEC_ERRCNT_EN.
package ring_pkg;

   typedef enum logic [1:0] {
      SEARCH,
      VERIFY,
      LOCKED
   } ring_state_t;

   localparam int RING_WIDTH    = 8;
   localparam int RING_LOCK_CNT = 4;
   localparam int ERRCNT_W      = 16;

endpackage

// File: rtl/ring_phase_decoder_onehot_encode.sv
// One-hot to binary encoder with an exactly-one flag.
// Reusable by any ring-phase consumer.
module onehot_encode #(
   parameter int WIDTH = 8,
   localparam int IW   = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] vec,
   output logic [IW-1:0]    idx,
   output logic             oh
);

   always_comb begin
      idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (vec[i]) idx = idx | IW'(i);
      end
   end

   // Clearing the lowest set bit leaves zero only for a single-bit vector.
   assign oh = (vec != '0) && ((vec & (vec - WIDTH'(1))) == '0);

endmodule

// File: rtl/ring_phase_decoder.sv
// Decodes and verifies a rotating one-hot ring vector.
// Optional error counter: RING_PHASE_DEC_ERRCNT_EN.
module ring_phase_decoder
   import ring_pkg::*;
#(
   parameter int WIDTH    = RING_WIDTH,
   parameter int LOCK_CNT = RING_LOCK_CNT,
   localparam int IW      = $clog2(WIDTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [WIDTH-1:0]    phase_in,
   input  logic                phase_vld,
   output logic [IW-1:0]       idx_out,
   output logic                idx_vld,
   output logic                locked,
   output logic                wrap,
   output logic                err_onehot,
   output logic                err_seq,
   output logic [ERRCNT_W-1:0] err_cnt
);

   ring_state_t      state;
   logic [7:0]       good_cnt;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] expv;
   logic [IW-1:0]    enc_idx;
   logic             oh;
   logic             ok;

   onehot_encode #(.WIDTH(WIDTH)) u_enc (
      .vec (phase_in),
      .idx (enc_idx),
      .oh  (oh)
   );

   assign expv   = {prev[0], prev[WIDTH-1:1]};
   assign ok     = oh && (phase_in == expv);
   assign locked = (state == LOCKED);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= SEARCH;
         good_cnt   <= '0;
         prev       <= '0;
         idx_out    <= '0;
         idx_vld    <= 1'b0;
         wrap       <= 1'b0;
         err_onehot <= 1'b0;
         err_seq    <= 1'b0;
      end else begin
         idx_vld    <= 1'b0;
         wrap       <= 1'b0;
         err_onehot <= 1'b0;
         err_seq    <= 1'b0;
         if (phase_vld) begin
            err_onehot <= !oh;
            if (oh) begin
               idx_out <= enc_idx;
               idx_vld <= 1'b1;
               prev    <= phase_in;
            end
            unique case (state)
               SEARCH: begin
                  if (oh) begin
                     state    <= VERIFY;
                     good_cnt <= 8'd1;
                  end
               end
               VERIFY: begin
                  if (ok) begin
                     good_cnt <= good_cnt + 8'd1;
                     if (good_cnt + 8'd1 == 8'(LOCK_CNT)) state <= LOCKED;
                  end else if (oh) begin
                     good_cnt <= 8'd1;
                     err_seq  <= 1'b1;
                  end else begin
                     state    <= SEARCH;
                     good_cnt <= '0;
                  end
               end
               LOCKED: begin
                  if (ok) begin
                     wrap <= phase_in[WIDTH-1];
                  end else if (oh) begin
                     state    <= VERIFY;
                     good_cnt <= 8'd1;
                     err_seq  <= 1'b1;
                  end else begin
                     state    <= SEARCH;
                     good_cnt <= '0;
                  end
               end
               default: state <= SEARCH;
            endcase
         end
      end
   end

`ifdef RING_PHASE_DEC_ERRCNT_EN
   logic err_now;

   // Counts alongside the error pulse it accompanies.
   assign err_now = phase_vld && (!oh || (!ok && state != SEARCH));

   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt <= '0;
      end else if (err_now && err_cnt != '1) begin
         err_cnt <= err_cnt + 1'b1;
      end
   end
`else
   assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_ring_phase_decoder.sv
// Scoreboard bench for ring_phase_decoder (WIDTH=8, LOCK_CNT=4).
module tb_ring_phase_decoder;
   import ring_pkg::*;

   typedef struct packed {
      logic [2:0]  idx;
      logic        vld;
      logic        lck;
      logic        wrp;
      logic        eoh;
      logic        esq;
      logic [15:0] ecnt;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        phase_vld;
   logic [7:0]  phase_in;
   logic [2:0]  idx_out;
   logic        idx_vld;
   logic        locked;
   logic        wrap;
   logic        err_onehot;
   logic        err_seq;
   logic [15:0] err_cnt;

   obs_t        q[$];
   obs_t        m;
   ring_state_t m_state;
   logic [7:0]  m_prev;
   logic [7:0]  m_cnt;
   int          passed = 0;
   int          total  = 0;
   int          failed = 0;
   int          ncyc   = 0;
   int          wraps  = 0;
   logic [7:0]  cur;

   ring_phase_decoder dut (
      .clk        (clk),
      .rst        (rst),
      .phase_in   (phase_in),
      .phase_vld  (phase_vld),
      .idx_out    (idx_out),
      .idx_vld    (idx_vld),
      .locked     (locked),
      .wrap       (wrap),
      .err_onehot (err_onehot),
      .err_seq    (err_seq),
      .err_cnt    (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] o,
                      input logic [31:0] e);
      total++;
      assert (o === e) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic model(input logic r, input logic v, input logic [7:0] s);
      logic       oh;
      logic       ok;
      logic [7:0] e;
      if (r) begin
         m       = '0;
         m_state = SEARCH;
         m_prev  = '0;
         m_cnt   = '0;
         return;
      end
      m.vld = 1'b0;
      m.wrp = 1'b0;
      m.eoh = 1'b0;
      m.esq = 1'b0;
      if (!v) return;
      oh    = ($countones(s) == 1);
      e     = {m_prev[0], m_prev[7:1]};
      ok    = oh && (s == e);
      m.eoh = !oh;
      m.esq = oh && !ok && (m_state != SEARCH);
      m.wrp = (m_state == LOCKED) && ok && s[7];
      if (oh) begin
         for (int i = 0; i < 8; i++) if (s[i]) m.idx = 3'(i);
         m.vld  = 1'b1;
         m_prev = s;
      end
      if (!oh) begin
         m_state = SEARCH;
         m_cnt   = 0;
      end else if (m_state == SEARCH || !ok) begin
         m_state = VERIFY;
         m_cnt   = 1;
      end else if (m_state == VERIFY) begin
         m_cnt++;
         if (m_cnt == 4) m_state = LOCKED;
      end
      m.lck = (m_state == LOCKED);
`ifdef RING_PHASE_DEC_ERRCNT_EN
      if ((m.eoh || m.esq) && m.ecnt != 16'hFFFF) m.ecnt++;
`endif
   endtask

   task automatic cyc(input logic r, input logic v, input logic [7:0] s);
      obs_t e;
      obs_t o;
      rst       = r;
      phase_vld = v;
      phase_in  = s;
      model(r, v, s);
      q.push_back(m);
      @(posedge clk);
      #1;
      ncyc++;
      o = {idx_out, idx_vld, locked, wrap, err_onehot, err_seq, err_cnt};
      e = q.pop_front();
      chk($sformatf("cyc%0d", ncyc), {8'b0, o}, {8'b0, e});
      if (wrap) wraps++;
   endtask

   initial begin
      repeat (3) cyc(1'b1, 1'b0, 8'h00);
      chk("reset_locked", {31'b0, locked}, 32'd0);
      chk("reset_idx", {29'b0, idx_out}, 32'd0);
      chk("reset_errcnt", {16'b0, err_cnt}, 32'd0);

      cur = 8'h80;
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b1, cur);
         cur = {cur[0], cur[7:1]};
      end
      chk("lock_rise", {31'b0, locked}, 32'd1);
      chk("lock_idx", {29'b0, idx_out}, 32'd4);
      chk("no_wrap_before_lock", wraps, 32'd0);

      for (int i = 0; i < 16; i++) begin
         cyc(1'b0, 1'b1, cur);
         if (wrap) chk("wrap_idx", {29'b0, idx_out}, 32'd7);
         cur = {cur[0], cur[7:1]};
      end
      chk("wrap_count", wraps, 32'd2);

      for (int i = 0; i < 8 && cur != 8'h20; i++) begin
         cyc(1'b0, 1'b1, cur);
         cur = {cur[0], cur[7:1]};
      end
      cyc(1'b0, 1'b1, 8'h08);
      chk("seq_err", {31'b0, err_seq}, 32'd1);
      chk("seq_unlock", {31'b0, locked}, 32'd0);
      cur = 8'h04;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b1, cur);
         cur = {cur[0], cur[7:1]};
      end
      chk("relock", {31'b0, locked}, 32'd1);
`ifdef RING_PHASE_DEC_ERRCNT_EN
      chk("errcnt_seq", {16'b0, err_cnt}, 32'd1);
`else
      chk("errcnt_off", {16'b0, err_cnt}, 32'd0);
`endif

      cyc(1'b1, 1'b0, 8'h00);
      cyc(1'b0, 1'b1, 8'h80);
      cyc(1'b0, 1'b1, 8'h00);
      chk("oh_zero", {31'b0, err_onehot}, 32'd1);
      chk("oh_hold_idx", {29'b0, idx_out}, 32'd7);
      chk("oh_no_vld", {31'b0, idx_vld}, 32'd0);
      cyc(1'b0, 1'b1, 8'hC0);
      chk("oh_multi", {31'b0, err_onehot}, 32'd1);
      chk("oh_search", {31'b0, locked}, 32'd0);
      cyc(1'b0, 1'b0, 8'h00);
`ifdef RING_PHASE_DEC_ERRCNT_EN
      chk("errcnt_oh", {16'b0, err_cnt}, 32'd2);
`else
      chk("errcnt_oh", {16'b0, err_cnt}, 32'd0);
`endif

      cyc(1'b1, 1'b1, 8'h40);
      chk("rst_wins", {31'b0, idx_vld}, 32'd0);

      cur = 8'h80;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            cyc(1'b0, 1'b0, cur);
         end else begin
            cyc(1'b0, 1'b1, cur);
            cur = {cur[0], cur[7:1]};
         end
      end
      chk("gap_lock", {31'b0, locked}, 32'd1);

      cyc(1'b1, 1'b0, 8'h00);
      chk("mid_rst_locked", {31'b0, locked}, 32'd0);
      chk("mid_rst_idx", {29'b0, idx_out}, 32'd0);
      chk("mid_rst_errcnt", {16'b0, err_cnt}, 32'd0);

`ifdef RING_PHASE_DEC_ERRCNT_EN
      repeat (70000) cyc(1'b0, 1'b1, 8'h00);
      chk("errcnt_sat", {16'b0, err_cnt}, 32'h0000FFFF);
      cyc(1'b0, 1'b1, 8'hFF);
      chk("errcnt_hold", {16'b0, err_cnt}, 32'h0000FFFF);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/ring_phase_decoder.md
Name: ring_phase_decoder

Overview:
- Receive-side companion to the team's rotating one-hot ring counter. Each qualified sample of the ring vector is decoded to a binary phase index.
- Checks that every sample is strictly one-hot and follows the rotate-right sequence: MSB set, then down to LSB, then back to MSB.
- Declares lock after a run of correct steps and emits a once-per-revolution wrap strobe, i.e. a divide-by-WIDTH tick.
- Sits downstream of any ring-phase source; used for phase monitoring and fault detection.

Parameters:
- WIDTH, 8, ring width in bits; must be at least 2. Index width IW = $clog2(WIDTH).
- LOCK_CNT, 4, consecutive correct samples, seed included, needed to lock; range 2..255.

Ports:
- clk, input, 1, clock; all logic is rising-edge.
- rst, input, 1, synchronous active-high reset.
- phase_in, input, WIDTH, ring vector sample.
- phase_vld, input, 1, phase_in is sampled only when this is 1.
- idx_out, output, IW, binary position of the set bit.
- idx_vld, output, 1, 1-cycle pulse when idx_out is updated.
- locked, output, 1, level; ring sequence verified.
- wrap, output, 1, 1-cycle pulse per completed revolution while locked.
- err_onehot, output, 1, 1-cycle pulse; sample had zero bits or more than one bit set.
- err_seq, output, 1, 1-cycle pulse; sample was one-hot but not the expected rotation.
- err_cnt, output, 16, saturating error count (optional feature).

Behaviour:
- Reset and clock: reset is synchronous, active-high, on rst; clock is clk.
- Reset values: idx_out=0, idx_vld=0, locked=0, wrap=0, err_onehot=0, err_seq=0, err_cnt=0, state=SEARCH, good_cnt=0, prev=0.
- Latency: all outputs are registered and reflect the sample taken on the previous rising edge (1 cycle).
- phase_vld=0: no state, counter or prev change; all pulse outputs are 0; idx_out and locked hold.
- Per accepted sample S:
  - oh = (popcount(S)==1)
  - exp = {prev[0], prev[WIDTH-1:1]}
  - ok = oh && (S==exp)
- idx_out/idx_vld: if oh, idx_out is loaded with the index of the set bit and idx_vld=1, in any state. If !oh, idx_vld=0 and idx_out holds.
- err_onehot = !oh. err_seq = oh && !ok && state!=SEARCH. Errors are never asserted from SEARCH except err_onehot.
- prev is loaded with S whenever oh; prev is unchanged when !oh.
- States:
  - SEARCH: oh -> VERIFY, good_cnt=1. !oh -> stay.
  - VERIFY:
    - ok -> good_cnt+1; if the result equals LOCK_CNT -> LOCKED.
    - oh && !ok -> stay in VERIFY, reseed good_cnt=1 from S.
    - !oh -> SEARCH, good_cnt=0.
  - LOCKED:
    - ok -> stay.
    - oh && !ok -> VERIFY, good_cnt=1.
    - !oh -> SEARCH.
- locked = (state==LOCKED). It rises the cycle after the LOCK_CNT-th correct sample and falls the cycle after the first bad sample.
- wrap=1 when state==LOCKED at sample time, ok=1 and S has bit WIDTH-1 set (the LSB->MSB step). With a continuous valid stream, wrap period is exactly WIDTH samples.
- Simultaneous rst and phase_vld: rst wins and the sample is discarded.
- Reset mid-operation: immediate return to SEARCH with all reset values on the next edge.

Optional Feature:
- Macro: RING_PHASE_DEC_ERRCNT_EN.
- Defined: err_cnt increments by 1 on each cycle where err_onehot or err_seq is asserted. Increment is at most 1 per sample. It saturates at 16'hFFFF and clears only on rst.
- Undefined: no counter logic; err_cnt is tied to 0. The port is always present.

Decomposition:
- Shared package ring_pkg holds:
  - state enum ring_state_t {SEARCH, VERIFY, LOCKED}
  - default constants RING_WIDTH=8, RING_LOCK_CNT=4
  - ERRCNT_W=16
- One sub-module: onehot_encode. It is combinational and WIDTH-parameterised. Outputs are idx (IW bits) and oh (exactly-one flag). It is reusable by other ring consumers.

Test Plan:
- Lock: rst for 3 cycles, then phase_vld=1 with 10000000, 01000000, 00100000, 00010000, ... -> idx_out 7,6,5,4 each 1 cycle later; locked=1 on the cycle after the 4th sample; no error pulses.
- Wrap: continue the locked stream through 00000001 -> 10000000 -> wrap=1 exactly once per 8 samples, coincident with idx_out=7; no wrap before lock.
- Sequence error: while locked, inject 00001000 where 00100000 is expected -> err_seq=1 for 1 cycle; locked falls; relock after 3 further correct rotations from the reseed; err_cnt=1 if the feature is enabled.
- One-hot error: inject 00000000, then 11000000 -> err_onehot pulses twice; idx_vld=0 and idx_out held; state SEARCH; err_cnt=2 with the feature enabled, 0 without.
- Gaps and reset: toggle phase_vld low for random cycles mid-stream -> lock and index sequence unaffected. Assert rst while locked -> next cycle locked=0, idx_out=0, err_cnt=0.
- Saturation (feature enabled): force 70000 one-hot errors -> err_cnt holds 16'hFFFF with no wrap to 0.
